// File: rtl/detection_pkg.sv
// detection_pkg: shared types and defaults for the Mealy/Moore detection checker
package detection_pkg;
  typedef enum logic [1:0] {WARMUP = 2'b00, TRACK = 2'b01, FAULT = 2'b10} chk_state_t;
  localparam int CNT_W_DEFAULT = 4;
endpackage

// File: rtl/detection_checker_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones, sync active-high reset
module sat_counter #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge CLK)
    count <= Reset ? '0 : (inc && !(&count)) ? count + W'(1) : count;
endmodule

// File: rtl/detection_checker.sv
// detection_checker: checks every Mealy detection is echoed by the Moore machine LAG clocks later
module detection_checker
  import detection_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT,
  parameter int LAG   = 1
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Z_mealy,
  input  logic             Z_moore,
  output logic [CNT_W-1:0] mealyCount,
  output logic [CNT_W-1:0] mooreCount,
  output logic [CNT_W-1:0] missCount,
  output logic             Mismatch,
  output logic             Error,
  output logic [1:0]       checkState
);
  chk_state_t     state, state_nxt;
  logic [1:0]     fill, fill_nxt;
  logic [LAG-1:0] dl;
  logic [LAG:0]   sh;
  logic           mealy_d, miss;
  assign sh      = {dl, Z_mealy};
  assign mealy_d = dl[LAG-1];
  // delay contents are garbage until LAG edges after reset, so only compare outside WARMUP
  always_comb begin
    miss      = 1'b0;
    fill_nxt  = '0;
    state_nxt = WARMUP;
    miss      = (state == TRACK || state == FAULT) && (mealy_d != Z_moore);
    fill_nxt  = state == WARMUP ? fill + 2'd1 : 2'd0;
    state_nxt = state == WARMUP ? (fill == 2'(LAG - 1) ? TRACK : WARMUP) :
                state == TRACK  ? (miss ? FAULT : TRACK) :
                state == FAULT  ? FAULT : WARMUP;
  end
  always_ff @(posedge CLK)
    if (Reset) begin
      state    <= WARMUP;
      fill     <= '0;
      dl       <= '0;
      Mismatch <= 1'b0;
    end else begin
      state    <= state_nxt;
      fill     <= fill_nxt;
      dl       <= sh[LAG-1:0];
      Mismatch <= miss;
    end
  assign Error      = state == FAULT;
  assign checkState = state;
  sat_counter #(.W(CNT_W)) u_mealy (.CLK(CLK), .Reset(Reset), .inc(Z_mealy), .count(mealyCount));
  sat_counter #(.W(CNT_W)) u_moore (.CLK(CLK), .Reset(Reset), .inc(Z_moore), .count(mooreCount));
  sat_counter #(.W(CNT_W)) u_miss  (.CLK(CLK), .Reset(Reset), .inc(miss),    .count(missCount));
endmodule

// File: tb/tb_detection_checker.sv
// tb_detection_checker: LAG=1 and LAG=2 checkers driven by directed and random stimulus against a history-based model
module tb_detection_checker;
  localparam int CNT_W = 4;
  localparam int SAT   = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic z_mealy = 1'b0;
  logic z_moore [2];
  logic [CNT_W-1:0] mealy_cnt [2];
  logic [CNT_W-1:0] moore_cnt [2];
  logic [CNT_W-1:0] miss_cnt [2];
  logic mismatch [2];
  logic error [2];
  logic [1:0] check_state [2];
  int checks = 0;
  int errors = 0;
  int lag [2] = '{1, 2};
  int n = 0;
  bit mh [$];
  int mc [2], oc [2], xc [2];
  bit faulted [2], mm [2];
  bit p1 = 0, p2 = 0;
  always #5 clk = ~clk;
  detection_checker #(.CNT_W(CNT_W), .LAG(1)) u_dut1 (
    .CLK(clk), .Reset(rst), .Z_mealy(z_mealy), .Z_moore(z_moore[0]),
    .mealyCount(mealy_cnt[0]), .mooreCount(moore_cnt[0]), .missCount(miss_cnt[0]),
    .Mismatch(mismatch[0]), .Error(error[0]), .checkState(check_state[0])
  );
  detection_checker #(.CNT_W(CNT_W), .LAG(2)) u_dut2 (
    .CLK(clk), .Reset(rst), .Z_mealy(z_mealy), .Z_moore(z_moore[1]),
    .mealyCount(mealy_cnt[1]), .mooreCount(moore_cnt[1]), .missCount(miss_cnt[1]),
    .Mismatch(mismatch[1]), .Error(error[1]), .checkState(check_state[1])
  );
  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  // e1/e2 flip the Moore input away from a faithful echo of the Mealy output LAG edges ago
  task automatic step(input bit r, input bit m, input bit e1, input bit e2);
    bit o [2];
    int st;
    o[0] = p1 ^ e1;
    o[1] = p2 ^ e2;
    rst = r;
    z_mealy = m;
    z_moore[0] = o[0];
    z_moore[1] = o[1];
    @(posedge clk);
    p2 = p1;
    p1 = m;
    if (r) begin
      n = 0;
      mh.delete();
    end else begin
      n++;
      mh.push_back(m);
    end
    for (int k = 0; k < 2; k++) begin
      if (r) begin
        mc[k] = 0; oc[k] = 0; xc[k] = 0; faulted[k] = 0; mm[k] = 0;
      end else begin
        mm[k] = (n > lag[k]) && (mh[n - lag[k] - 1] != o[k]);
        if (mm[k]) faulted[k] = 1;
        if (mm[k] && xc[k] < SAT) xc[k]++;
        if (m && mc[k] < SAT) mc[k]++;
        if (o[k] && oc[k] < SAT) oc[k]++;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      st = (r || n < lag[k]) ? 0 : faulted[k] ? 2 : 1;
      check($sformatf("lag%0d mealyCount", lag[k]), int'(mealy_cnt[k]), mc[k]);
      check($sformatf("lag%0d mooreCount", lag[k]), int'(moore_cnt[k]), oc[k]);
      check($sformatf("lag%0d missCount", lag[k]), int'(miss_cnt[k]), xc[k]);
      check($sformatf("lag%0d Mismatch", lag[k]), int'(mismatch[k]), int'(mm[k]));
      check($sformatf("lag%0d Error", lag[k]), int'(error[k]), int'(faulted[k]));
      check($sformatf("lag%0d checkState", lag[k]), int'(check_state[k]), st);
    end
  endtask
  initial begin
    z_moore[0] = 1'b0;
    z_moore[1] = 1'b0;
    step(1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    repeat (20) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 79) == 0, 1'($urandom), $urandom_range(0, 59) == 0, $urandom_range(0, 59) == 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
